// File: rtl/serial_tx_arbiter_if.sv
// serial_tx_arbiter_if
//   Bundles the requester handshake and the transmitter-facing outputs
//   of serial_tx_arbiter.
//
//   req       producers -> arbiter   per-requester byte request (level)
//   req_data  producers -> arbiter   byte for requester i in [8i+7:8i]
//   ack       arbiter -> producers   one-cycle one-hot "byte accepted"
//   ser_data  arbiter -> serial      byte held stable for the whole frame
//   ser_txe   arbiter -> serial      one-cycle transmit-enable pulse
//   busy      arbiter -> observers   flushing or a frame is in flight
//   grant_id  arbiter -> observers   index of the last granted requester
//
//   Modports: master = producer side, slave = arbiter side.
interface serial_tx_arbiter_if #(
    parameter int NREQ = 4
);
    localparam int ID_W = $clog2(NREQ);

    logic [NREQ-1:0]   req;
    logic [8*NREQ-1:0] req_data;
    logic [NREQ-1:0]   ack;
    logic [7:0]        ser_data;
    logic              ser_txe;
    logic              busy;
    logic [ID_W-1:0]   grant_id;

    modport master (
        output req, req_data,
        input  ack, ser_data, ser_txe, busy, grant_id
    );

    modport slave (
        input  req, req_data,
        output ack, ser_data, ser_txe, busy, grant_id
    );
endinterface

// File: rtl/serial_tx_arbiter.sv
// serial_tx_arbiter
//   Shares one `serial` UART transmitter between NREQ byte producers.
//   A winner is chosen from the pending requests, its byte is latched onto
//   the transmitter data input, a one-cycle txe pulse is fired, and the
//   data is then held for the worst-case frame time. `serial` reports no
//   busy state, so the frame is timed here with a counter. After reset the
//   block first waits one full frame time (FLUSH), because `serial` itself
//   has no reset and may still be shifting out a frame.
//
//   Ports:
//     clk   system clock, shared with `serial`
//     rst   asynchronous reset, active-high
//     bus   serial_tx_arbiter_if.slave: req, req_data in; ack, ser_data,
//           ser_txe, busy, grant_id out (all outputs registered)
//
//   Parameters: NREQ (2..8), CLK_FREQ and BAUD (must match `serial`).
//
//   Build option: define SERIAL_ARB_FIXED_PRIO_EN for fixed priority
//   (lowest index wins, no round-robin pointer). Default is round-robin.
module serial_tx_arbiter #(
    parameter int NREQ     = 4,
    parameter int CLK_FREQ = 50_000_000,
    parameter int BAUD     = 9600
) (
    input  logic               clk,
    input  logic               rst,
    serial_tx_arbiter_if.slave bus
);
    localparam int CLK_MUL    = CLK_FREQ / (BAUD * 16);
    localparam int FRAME_CLKS = 12 * 16 * (CLK_MUL + 1);
    localparam int CNT_W      = $clog2(FRAME_CLKS + 1);
    localparam int ID_W       = $clog2(NREQ);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FRAME_CLKS - 1);
    localparam logic [NREQ-1:0]  ONE_HOT0 = NREQ'(1);

    typedef enum logic [1:0] {
        ST_FLUSH = 2'd0,
        ST_IDLE  = 2'd1,
        ST_SEND  = 2'd2
    } state_t;

    state_t          state_r,    state_nxt_s;
    logic [CNT_W-1:0] cnt_r,     cnt_nxt_s;
    logic [NREQ-1:0] ack_r,      ack_nxt_s;
    logic [7:0]      ser_data_r, ser_data_nxt_s;
    logic            ser_txe_r,  ser_txe_nxt_s;
    logic            busy_r,     busy_nxt_s;
    logic [ID_W-1:0] grant_id_r, grant_id_nxt_s;

    logic            grant_s;
    logic [ID_W-1:0] win_lo_s;
    logic [ID_W-1:0] win_s;
    logic [7:0]      win_data_s;

    // A grant happens on any edge where the block is idle and someone asks.
    assign grant_s = (state_r == ST_IDLE) && (|bus.req);

    // Lowest-index pending request; descending scan so the lowest hit is kept.
    always_comb begin
        win_lo_s = {ID_W{1'b0}};
        for (int j = NREQ - 1; j >= 0; j--) begin
            win_lo_s = bus.req[j] ? ID_W'(j) : win_lo_s;
        end
    end

`ifdef SERIAL_ARB_FIXED_PRIO_EN
    // Fixed priority: the lowest pending index always wins.
    assign win_s = win_lo_s;
`else
    logic [ID_W-1:0] ptr_r;
    logic [ID_W-1:0] win_hi_s;
    logic            found_hi_s;
    logic [ID_W-1:0] ptr_after_s;

    // Round-robin: prefer the lowest request at/above the pointer, else wrap
    // around to the lowest request overall.
    always_comb begin
        win_hi_s   = {ID_W{1'b0}};
        found_hi_s = 1'b0;
        for (int j = NREQ - 1; j >= 0; j--) begin
            found_hi_s = (bus.req[j] && (ID_W'(j) >= ptr_r)) ? 1'b1     : found_hi_s;
            win_hi_s   = (bus.req[j] && (ID_W'(j) >= ptr_r)) ? ID_W'(j) : win_hi_s;
        end
        win_s = found_hi_s ? win_hi_s : win_lo_s;
    end

    // Pointer moves one past the winner, wrapping at NREQ.
    assign ptr_after_s = (win_s == ID_W'(NREQ - 1)) ? {ID_W{1'b0}} : (win_s + ID_W'(1));

    // Round-robin pointer register, advanced only on grant edges.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_r <= {ID_W{1'b0}};
        end else if (grant_s) begin
            ptr_r <= ptr_after_s;
        end else begin
            ptr_r <= ptr_r;
        end
    end
`endif

    // Byte of the current winner, selected with a constant-index mux.
    always_comb begin
        win_data_s = 8'h00;
        for (int j = 0; j < NREQ; j++) begin
            win_data_s = (win_s == ID_W'(j)) ? bus.req_data[8*j +: 8] : win_data_s;
        end
    end

    // Next-state and next-output logic; ack/txe default low so they pulse once.
    always_comb begin
        state_nxt_s    = state_r;
        cnt_nxt_s      = cnt_r;
        ack_nxt_s      = {NREQ{1'b0}};
        ser_txe_nxt_s  = 1'b0;
        ser_data_nxt_s = ser_data_r;
        busy_nxt_s     = busy_r;
        grant_id_nxt_s = grant_id_r;
        case (state_r)
            ST_FLUSH, ST_SEND: begin
                if (cnt_r == CNT_LAST) begin
                    state_nxt_s = ST_IDLE;
                    busy_nxt_s  = 1'b0;
                    cnt_nxt_s   = {CNT_W{1'b0}};
                end else begin
                    cnt_nxt_s   = cnt_r + CNT_W'(1);
                end
            end
            ST_IDLE: begin
                if (grant_s) begin
                    state_nxt_s    = ST_SEND;
                    ser_data_nxt_s = win_data_s;
                    ack_nxt_s      = ONE_HOT0 << win_s;
                    ser_txe_nxt_s  = 1'b1;
                    grant_id_nxt_s = win_s;
                    busy_nxt_s     = 1'b1;
                    cnt_nxt_s      = {CNT_W{1'b0}};
                end else begin
                    state_nxt_s    = ST_IDLE;
                end
            end
            default: begin
                // Unreachable encoding: recover through a full flush.
                state_nxt_s = ST_FLUSH;
                busy_nxt_s  = 1'b1;
                cnt_nxt_s   = {CNT_W{1'b0}};
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r    <= ST_FLUSH;
            cnt_r      <= {CNT_W{1'b0}};
            ack_r      <= {NREQ{1'b0}};
            ser_data_r <= 8'h00;
            ser_txe_r  <= 1'b0;
            busy_r     <= 1'b1;
            grant_id_r <= {ID_W{1'b0}};
        end else begin
            state_r    <= state_nxt_s;
            cnt_r      <= cnt_nxt_s;
            ack_r      <= ack_nxt_s;
            ser_data_r <= ser_data_nxt_s;
            ser_txe_r  <= ser_txe_nxt_s;
            busy_r     <= busy_nxt_s;
            grant_id_r <= grant_id_nxt_s;
        end
    end

    assign bus.ack      = ack_r;
    assign bus.ser_data = ser_data_r;
    assign bus.ser_txe  = ser_txe_r;
    assign bus.busy     = busy_r;
    assign bus.grant_id = grant_id_r;
endmodule

// File: tb/tb_serial_tx_arbiter.sv
// tb_serial_tx_arbiter
//   Self-checking bench for serial_tx_arbiter with NREQ=4,
//   CLK_FREQ=1_600_000, BAUD=10_000 (frame time 2112 clocks).
//   Table-driven grant sequences, hand-written reset/withdraw sequences and
//   a randomized phase checked against a behavioural arbitration model.
//   Honours SERIAL_ARB_FIXED_PRIO_EN for its expectations.
module tb_serial_tx_arbiter;
    localparam int NREQ  = 4;
    localparam int FRAME = 2112;

    logic clk = 1'b0;
    logic rst;

    serial_tx_arbiter_if #(.NREQ(NREQ)) bus ();

    serial_tx_arbiter #(
        .NREQ     (NREQ),
        .CLK_FREQ (1_600_000),
        .BAUD     (10_000)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    // Free-running clock, 10 time units per period.
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] add;       // request bits raised before waiting
        logic [3:0] drop;      // request bits cleared after the ack
        logic [3:0] exp_ack;
        logic [1:0] exp_id;
        logic [7:0] exp_data;
    } vec_t;

    vec_t       tbl [12];
    int         total;
    int         bad;
    int         mptr;
    logic [7:0] pdata [NREQ];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic set_data();
        bus.req_data = {pdata[3], pdata[2], pdata[1], pdata[0]};
    endtask

    // Waits for a nonzero ack, bounded; also reports the first sample with busy low.
    task automatic wait_ack(input int limit, output int n, output int idle_at);
        n = 0;
        idle_at = 0;
        do begin
            tick(1);
            n++;
            if (idle_at == 0 && !bus.busy) idle_at = n;
        end while (bus.ack == 4'b0000 && n < limit);
    endtask

    // Reference arbitration: which pending port wins given the pointer.
    function automatic int model_pick(input logic [3:0] m, input int p);
        int idx;
`ifdef SERIAL_ARB_FIXED_PRIO_EN
        for (int k = 0; k < NREQ; k++) begin
            idx = k;
            if (m[idx[1:0]]) return idx;
        end
`else
        for (int k = 0; k < NREQ; k++) begin
            idx = (p + k) % NREQ;
            if (m[idx[1:0]]) return idx;
        end
`endif
        return -1;
    endfunction

    // Hard stop if something hangs.
    initial begin
        #(90000 * 10);
        $display("FAIL watchdog: simulation still running at cycle 90000, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n;
        int idle_at;
        int early;
        int early_idle;
        int busy_at_frame;
        int seen;
        int w;
        logic [3:0] mask;
        logic [3:0] exp_ack;

        total = 0;
        bad   = 0;
        mptr  = 0;

        tbl[0] = '{4'b1111, 4'b0001, 4'b0001, 2'd0, 8'h11};
        tbl[1] = '{4'b0000, 4'b0010, 4'b0010, 2'd1, 8'h22};
        tbl[2] = '{4'b0000, 4'b0100, 4'b0100, 2'd2, 8'h33};
        tbl[3] = '{4'b0000, 4'b1000, 4'b1000, 2'd3, 8'h44};
`ifdef SERIAL_ARB_FIXED_PRIO_EN
        tbl[4]  = '{4'b0101, 4'b0000, 4'b0001, 2'd0, 8'h11};
        tbl[5]  = '{4'b0000, 4'b0000, 4'b0001, 2'd0, 8'h11};
        tbl[6]  = '{4'b0000, 4'b0000, 4'b0001, 2'd0, 8'h11};
        tbl[7]  = '{4'b0000, 4'b0101, 4'b0001, 2'd0, 8'h11};
        tbl[8]  = '{4'b1001, 4'b0000, 4'b0001, 2'd0, 8'h11};
        tbl[9]  = '{4'b0000, 4'b0000, 4'b0001, 2'd0, 8'h11};
        tbl[10] = '{4'b0000, 4'b0000, 4'b0001, 2'd0, 8'h11};
        tbl[11] = '{4'b0000, 4'b1001, 4'b0001, 2'd0, 8'h11};
`else
        tbl[4]  = '{4'b0101, 4'b0000, 4'b0001, 2'd0, 8'h11};
        tbl[5]  = '{4'b0000, 4'b0000, 4'b0100, 2'd2, 8'h33};
        tbl[6]  = '{4'b0000, 4'b0000, 4'b0001, 2'd0, 8'h11};
        tbl[7]  = '{4'b0000, 4'b0101, 4'b0100, 2'd2, 8'h33};
        tbl[8]  = '{4'b1001, 4'b0000, 4'b1000, 2'd3, 8'h44};
        tbl[9]  = '{4'b0000, 4'b0000, 4'b0001, 2'd0, 8'h11};
        tbl[10] = '{4'b0000, 4'b0000, 4'b1000, 2'd3, 8'h44};
        tbl[11] = '{4'b0000, 4'b1001, 4'b0001, 2'd0, 8'h11};
`endif

        // ---------------- reset values ----------------
        rst     = 1'b1;
        bus.req = 4'b0000;
        for (int p = 0; p < NREQ; p++) pdata[p] = 8'h00;
        set_data();
        tick(3);
        check("rst_txe",   32'(bus.ser_txe),  32'd0);
        check("rst_ack",   32'(bus.ack),      32'd0);
        check("rst_data",  32'(bus.ser_data), 32'h00);
        check("rst_grant", 32'(bus.grant_id), 32'd0);
        check("rst_busy",  32'(bus.busy),     32'd1);

        // ---------------- flush then first grant ----------------
        pdata[0] = 8'hA5;
        set_data();
        rst = 1'b0;
        n = 0; early = 0; early_idle = 0; busy_at_frame = 1;
        while (bus.ack == 4'b0000 && n < FRAME + 50) begin
            tick(1);
            n++;
            if (n == 5) bus.req = 4'b0001;
            if (bus.ser_txe && bus.ack == 4'b0000) early = 1;
            if (n < FRAME && !bus.busy) early_idle = 1;
            if (n == FRAME) busy_at_frame = 32'(bus.busy);
        end
        check("flush_latency",    32'(n),             32'(FRAME + 1));
        check("flush_busy_early", 32'(early_idle),    32'd0);
        check("flush_idle_busy",  32'(busy_at_frame), 32'd0);
        check("flush_txe_alone",  32'(early),         32'd0);
        check("g0_ack",   32'(bus.ack),      32'h1);
        check("g0_txe",   32'(bus.ser_txe),  32'd1);
        check("g0_data",  32'(bus.ser_data), 32'hA5);
        check("g0_busy",  32'(bus.busy),     32'd1);
        check("g0_grant", 32'(bus.grant_id), 32'd0);
        bus.req = 4'b0000;
        tick(1);
        check("g0_txe_pulse", 32'(bus.ser_txe),  32'd0);
        check("g0_ack_pulse", 32'(bus.ack),      32'd0);
        check("g0_data_hold", 32'(bus.ser_data), 32'hA5);

        // ---------------- reset mid-frame ----------------
        tick(498);
        pdata[0] = 8'h11; pdata[1] = 8'h22; pdata[2] = 8'h33; pdata[3] = 8'h44;
        set_data();
        bus.req = 4'b1111;
        rst = 1'b1;
        #1;
        check("midrst_data", 32'(bus.ser_data), 32'h00);
        check("midrst_txe",  32'(bus.ser_txe),  32'd0);
        check("midrst_ack",  32'(bus.ack),      32'd0);
        check("midrst_busy", 32'(bus.busy),     32'd1);
        tick(2);
        rst  = 1'b0;
        mptr = 0;

        // ---------------- table-driven grant sequences ----------------
        for (int i = 0; i < 12; i++) begin
            bus.req = bus.req | tbl[i].add;
            wait_ack(FRAME + 50, n, idle_at);
            check($sformatf("tbl%0d_gap", i),   32'(n),             32'(FRAME + 1));
            check($sformatf("tbl%0d_idle", i),  32'(idle_at),       32'(FRAME));
            check($sformatf("tbl%0d_ack", i),   32'(bus.ack),       32'(tbl[i].exp_ack));
            check($sformatf("tbl%0d_grant", i), 32'(bus.grant_id),  32'(tbl[i].exp_id));
            check($sformatf("tbl%0d_data", i),  32'(bus.ser_data),  32'(tbl[i].exp_data));
            check($sformatf("tbl%0d_txe", i),   32'(bus.ser_txe),   32'd1);
            mptr = (int'(tbl[i].exp_id) + 1) % NREQ;
            bus.req = bus.req & ~tbl[i].drop;
        end

        // ---------------- request withdrawn during a frame ----------------
        seen = 0;
        tick(100);
        bus.req[1] = 1'b1;
        tick(200);
        bus.req[1] = 1'b0;
        n = 300;
        while (bus.busy && n < FRAME + 50) begin
            tick(1);
            n++;
            if (bus.ack != 4'b0000) seen = 1;
        end
        check("wd_frame_end", 32'(n), 32'(FRAME));
        repeat (20) begin
            tick(1);
            if (bus.ack != 4'b0000 || bus.ser_txe) seen = 1;
        end
        check("wd_no_ack",    32'(seen),         32'd0);
        check("wd_idle_busy", 32'(bus.busy),     32'd0);
        check("wd_data_hold", 32'(bus.ser_data), 32'h11);

        // ---------------- randomized grants vs reference model ----------------
        for (int it = 0; it < 6; it++) begin
            mask = 4'($urandom_range(1, 15));
            for (int p = 0; p < NREQ; p++) pdata[p] = 8'($urandom);
            set_data();
            w = model_pick(mask, mptr);
            exp_ack = 4'b0001 << w;
            bus.req = mask;
            wait_ack(4, n, idle_at);
            check($sformatf("rnd%0d_latency", it), 32'(n),            32'd1);
            check($sformatf("rnd%0d_ack", it),     32'(bus.ack),      32'(exp_ack));
            check($sformatf("rnd%0d_grant", it),   32'(bus.grant_id), 32'(w));
            check($sformatf("rnd%0d_data", it),    32'(bus.ser_data), 32'(pdata[w]));
            check($sformatf("rnd%0d_txe", it),     32'(bus.ser_txe),  32'd1);
            mptr = (w + 1) % NREQ;
            bus.req = 4'b0000;
            tick(1);
            check($sformatf("rnd%0d_txe_pulse", it), 32'(bus.ser_txe), 32'd0);
            check($sformatf("rnd%0d_busy", it),      32'(bus.busy),    32'd1);
            n = 1;
            while (bus.busy && n < FRAME + 50) begin
                tick(1);
                n++;
            end
            check($sformatf("rnd%0d_frame", it), 32'(n), 32'(FRAME));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/serial_tx_arbiter.md
Name: serial_tx_arbiter

Overview:
Shares the single `serial` UART transmitter between NREQ byte producers. It arbitrates round-robin and latches the winner's byte onto the transmitter's data input. It fires the one-cycle transmit-enable pulse, then holds the data stable for the worst-case frame time. `serial` has no busy output, so this block times each frame itself.

Parameters:
NREQ, 4, number of requesters (2..8)
CLK_FREQ, 50_000_000, clk frequency in Hz; must equal the value given to `serial`
BAUD, 9600, line rate; must equal the value given to `serial`
CLK_MUL (localparam), CLK_FREQ/(BAUD*16) integer division, the same oversample divider `serial` uses
FRAME_CLKS (localparam), 12*16*(CLK_MUL+1), worst-case clocks from the txe pulse to the line returning idle
CNT_W (localparam), $clog2(FRAME_CLKS+1), frame counter width

Ports:
clk  in  1  system clock, shared with `serial`
rst  in  1  asynchronous reset, active-high
req  in  NREQ  per-requester byte request; level, held until ack
req_data  in  8*NREQ  byte for requester i in bits [8i+7:8i]
ack  out  NREQ  one-cycle one-hot pulse: byte accepted, requester may change data or drop req
ser_data  out  8  to `serial`.data; registered, stable for the whole frame
ser_txe  out  1  to `serial`.txe; one-cycle pulse per byte
busy  out  1  high while flushing or a frame is in flight
grant_id  out  $clog2(NREQ)  index of the last granted requester

Behaviour:
- All outputs are registered. Reset is asynchronous, active-high.
- Reset values:
  - ser_txe=0, ack=0, ser_data=8'h00, grant_id=0.
  - RR pointer=0, counter=0.
  - state=FLUSH, busy=1.
- State FLUSH:
  - `serial` has no reset, so its line may be mid-frame; the block must not grant.
  - Counter increments every clk. At counter==FRAME_CLKS-1: state->IDLE, busy<=0, counter<=0.
- State IDLE:
  - If no req bit is set, nothing changes.
  - Otherwise choose winner w = first set req bit scanning from the RR pointer upward, wrapping modulo NREQ.
  - On that same edge:
    - ser_data<=req_data slice w, ack<=onehot(w), ser_txe<=1, grant_id<=w.
    - pointer<=(w+1) mod NREQ, busy<=1, counter<=0.
    - state->SEND.
- State SEND:
  - ser_txe<=0 and ack<=0 on the first edge, so each is exactly one cycle wide.
  - Counter increments every clk. At counter==FRAME_CLKS-1: state->IDLE, busy<=0, counter<=0.
  - req is ignored in this state.
- Latency:
  - req sampled high in IDLE at edge N: ack and ser_txe are high during cycle N+1.
  - Back-to-back grants have txe rising edges exactly FRAME_CLKS+1 cycles apart.
- ser_data changes only on a grant edge. It holds after a frame ends, since `serial` reads data combinationally.
- Requester protocol:
  - Hold req and req_data stable until ack.
  - req may be withdrawn before ack, with no side effects.
  - req still high in the cycle after ack counts as a new byte.
- Simultaneous requests: exactly one grant per frame. The pointer guarantees each continuously-requesting port is served within NREQ frames.
- Reset asserted mid-SEND: outputs return to reset values immediately and the full FLUSH wait repeats after release. The interrupted byte is lost and is not re-acked.
- No FIFO. No combinational path from req to any output.

Optional Feature:
SERIAL_ARB_FIXED_PRIO_EN:
- Defined: fixed priority; the lowest-index set req always wins, the RR pointer is not implemented, and port 0 may starve others.
- Undefined (default): round-robin as above.

Test Plan:
- Params CLK_FREQ=1_600_000, BAUD=10_000: CLK_MUL=10, FRAME_CLKS=2112.
- Reset release, req[0]=1 with data 8'hA5 from cycle 5 -> no ack/txe for 2112 cycles; then ack=4'b0001 and ser_txe=1 for one cycle together, ser_data=8'hA5, busy=1. An instantiated `serial` emits idle, start bit, LSB-first 1,0,1,0,0,1,0,1, then stop.
- After flush, req=4'b1111 with data 11/22/33/44, each dropped on its ack -> grants 0,1,2,3 in order; txe rising edges 2113 cycles apart; ser_data sequence 11,22,33,44.
- req[0] and req[2] held continuously, pointer at 0 -> grant_id alternates 0,2,0,2; port 1 and port 3 are never acked.
- req[1] raised then dropped while in SEND, before any grant -> ack[1] never pulses; block stays IDLE with busy=0 afterwards.
- rst pulsed 500 cycles into SEND -> ser_txe=0, ack=0, ser_data=0 immediately; busy=1 for 2112 cycles after release, then a pending req is granted.
- With SERIAL_ARB_FIXED_PRIO_EN, req[0] and req[3] held -> every grant_id=0 and ack[3] is never seen. Without the macro, the same stimulus alternates 0,3.
